linebuf_rdctl: RTL and testbench

LINEBUF_RDCTL -- requirements
Module: linebuf_rdctl

---
 rtl/linebuf_rdctl_pkg.sv | 44 ++++
 rtl/linebuf_rdctl_pix_counter.sv | 40 ++++
 rtl/linebuf_rdctl.sv | 120 ++++++++++++
 tb/tb_linebuf_rdctl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/linebuf_rdctl_pkg.sv
// Shared defaults, FSM encoding and window tag for the linebuf read controller.
// Optional stride-2 windowing is enabled with LINEBUF_RDCTL_STRIDE2_EN.
package linebuf_rdctl_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int AWIDTH_DEF = 12;
    localparam int IMG_W_DEF  = 12;
    localparam int IMG_H_DEF  = 8;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       issued;
        logic       row_ok;
        logic       col_ok;
        logic [3:0] row;
        logic [3:0] col;
    } tag_t;

    // Tag for the pixel just issued; row/col are relative to the window origin.
    function automatic tag_t make_tag(
        input logic             issued,
        input logic [CNT_W-1:0] row,
        input logic [CNT_W-1:0] col
    );
        tag_t t;
        t = '0;
        if (issued) begin
            t.issued = 1'b1;
            t.row_ok = row >= CNT_W'(4);
            t.col_ok = col >= CNT_W'(4);
            t.row    = 4'(row - CNT_W'(4));
            t.col    = 4'(col - CNT_W'(4));
        end
        return t;
    endfunction

endpackage

// File: rtl/linebuf_rdctl_pix_counter.sv
// Raster row/col counter for the linebuf read controller.
// Column wraps at IMG_W-1; last flags the final pixel of the frame.
module pix_counter
    import linebuf_rdctl_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             last
);

    logic col_end;

    assign col_end = col == CNT_W'(IMG_W - 1);
    assign last    = col_end && (row == CNT_W'(IMG_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= last ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/linebuf_rdctl.sv
// Read-address sequencer feeding a 5x5 linebuf, with aligned window-valid tags.
// Define LINEBUF_RDCTL_STRIDE2_EN to keep only even-aligned windows.
module linebuf_rdctl
    import linebuf_rdctl_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    output logic [AWIDTH-1:0] read_addr,
    output logic              read_en,
    output logic              win_valid,
    output logic [3:0]        win_row,
    output logic [3:0]        win_col,
    output logic              busy,
    output logic              done
);

    if (DWIDTH < 1 || IMG_H < 5) begin : g_cfg_bad
        $error("linebuf_rdctl: bad DWIDTH/IMG_H");
    end

    state_t           state;
    logic             drain_cnt;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             last;
    logic             cnt_clr;
    logic             cnt_en;
    tag_t             tag_q;
    logic             win_ok;

    assign cnt_clr = (state == IDLE) && start;
    assign cnt_en  = state == READ;

    pix_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_pix_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .row (row),
        .col (col),
        .last(last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            read_addr <= '0;
            read_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= READ;
                        read_addr <= base_addr;
                        read_en   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                READ: begin
                    if (last) begin
                        state     <= DRAIN;
                        read_en   <= 1'b0;
                        drain_cnt <= 1'b0;
                    end else begin
                        read_addr <= read_addr + AWIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LINEBUF_RDCTL_STRIDE2_EN
    assign win_ok = tag_q.issued && tag_q.row_ok && tag_q.col_ok &&
                    !tag_q.row[0] && !tag_q.col[0];
`else
    assign win_ok = tag_q.issued && tag_q.row_ok && tag_q.col_ok;
`endif

    // Two stages: memory latency plus the write into the linebuf newest tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            tag_q     <= make_tag(state == READ, row, col);
            win_valid <= win_ok;
            win_row   <= tag_q.row;
            win_col   <= tag_q.col;
        end
    end

endmodule

// File: tb/tb_linebuf_rdctl.sv
// Self-checking bench for linebuf_rdctl: table of frame runs plus reset corners.
module tb_linebuf_rdctl;

    localparam int W  = 12;
    localparam int H  = 8;
    localparam int AW = 12;
`ifdef LINEBUF_RDCTL_STRIDE2_EN
    localparam int EXP_WIN = 8;
`else
    localparam int EXP_WIN = 32;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] read_addr;
    logic          read_en;
    logic          win_valid;
    logic [3:0]    win_row;
    logic [3:0]    win_col;
    logic          busy;
    logic          done;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    linebuf_rdctl #(
        .DWIDTH(16),
        .AWIDTH(AW),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .read_addr(read_addr),
        .read_en  (read_en),
        .win_valid(win_valid),
        .win_row  (win_row),
        .win_col  (win_col),
        .busy     (busy),
        .done     (done)
    );

    // Memory returns data=address one cycle later; the linebuf stores it next edge.
    logic [AW-1:0] mem_data;
    logic          mem_vld = 1'b0;
    int            lb[W*H];
    int            lb_cnt = 0;
    logic          lb_clr = 1'b0;

    always @(posedge clk) begin
        mem_data <= read_addr;
        mem_vld  <= read_en;
        if (lb_clr) begin
            lb_cnt <= 0;
        end else if (mem_vld && lb_cnt < W*H) begin
            lb[lb_cnt] <= int'(mem_data);
            lb_cnt     <= lb_cnt + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_frame(
        input  int base,
        input  int glitch_at,
        input  bit glitch_done,
        input  int rst_at,
        output int nreads,
        output int nwins,
        output int last_rd,
        output int last_win,
        output int done_at
    );
        int idx0;
        nreads   = 0;
        nwins    = 0;
        last_rd  = -1;
        last_win = -1;
        done_at  = -1;
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(base);
        lb_clr    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lb_clr = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (read_en) begin
                chk("read_addr", int'(read_addr), (base + nreads) & 'hFFF);
                nreads++;
                last_rd = k;
            end
            if (win_valid) begin
                idx0 = int'(win_row) * W + int'(win_col);
                chk("win_pixel0", idx0 < W*H ? lb[idx0] : -1,
                    (base + idx0) & 'hFFF);
                chk("win_align", lb_cnt,
                    (int'(win_row) + 4) * W + int'(win_col) + 5);
`ifdef LINEBUF_RDCTL_STRIDE2_EN
                chk("win_even", int'(win_row[0] | win_col[0]), 0);
`endif
                nwins++;
                last_win = k;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_outputs", int'({read_addr, read_en, win_valid,
                    win_row, win_col, busy, done}), 0);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("no_resume", int'({read_en, busy, win_valid}), 0);
                end
                return;
            end
            if (done) begin
                done_at = k;
                if (glitch_done) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("done_one_cycle", int'({done, busy}), 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("idle_after_done", int'({read_en, busy}), 0);
                end
                break;
            end
            start = (k == glitch_at);
            @(negedge clk);
        end
        start = 1'b0;
        if (done_at < 0) chk("frame_timeout", 0, 1);
    endtask

    typedef struct {
        int base;
        int glitch_at;
        bit glitch_done;
        int exp_reads;
        int exp_wins;
    } vec_t;

    vec_t vecs[4];
    int   nr, nw, lr, lw, da;

    initial begin
        vecs[0] = '{'h100, -1, 1'b0, W*H, EXP_WIN};
        vecs[1] = '{'h000, -1, 1'b0, W*H, EXP_WIN};
        vecs[2] = '{'h100, 20, 1'b1, W*H, EXP_WIN};
        vecs[3] = '{'hF80, 60, 1'b0, W*H, EXP_WIN};

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", int'({read_addr, read_en, win_valid,
            win_row, win_col, busy, done}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", int'({read_en, busy, done}), 0);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].base, vecs[i].glitch_at, vecs[i].glitch_done,
                      -1, nr, nw, lr, lw, da);
            chk("reads", nr, vecs[i].exp_reads);
            chk("windows", nw, vecs[i].exp_wins);
            chk("last_read_cycle", lr, W*H - 1);
            chk("last_win_cycle", lw, lr + 2);
            chk("done_cycle", da, lr + 3);
        end

        run_frame('h200, -1, 1'b0, 30, nr, nw, lr, lw, da);
        chk("reads_before_rst", nr, 31);
        chk("no_done_after_rst", da, -1);

        run_frame('h200, -1, 1'b0, -1, nr, nw, lr, lw, da);
        chk("post_rst_reads", nr, W*H);
        chk("post_rst_windows", nw, EXP_WIN);
        chk("post_rst_done", da, lr + 3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
